// File: rtl/sd_uart_rx_gen2.sv
// ---------------------------------------------------------------------------
// sd_uart_rx_gen2 -- asynchronous serial receiver with 3-sample majority vote
//
// Receives frames of 1 start bit, DATA_BITS data bits (LSB first), an
// optional parity bit and STOP_BITS stop bits. Each bit is sampled three
// times around its centre and decided by 2-of-3 majority. The frame result
// (data word, parity error, frame error) is published with a one-cycle
// po_flag pulse and held until the next frame completes.
//
// Optional feature macro: SD_UART_RX_FALSE_START_EN
//   defined   -> a START bit whose majority is 1 aborts back to IDLE (no flag)
//   undefined -> START always proceeds to DATA
//
// Ports:
//   sys_clk      in   system clock, rising edge
//   sys_rst_n    in   asynchronous active-low reset
//   rx           in   asynchronous serial line, idle high
//   po_data      out  [DATA_BITS-1:0] last received data word
//   po_flag      out  one-cycle pulse: po_data/parity_err/frame_err valid
//   parity_err   out  parity mismatch on the flagged frame (0 if PARITY=0)
//   frame_err    out  a stop bit decided low on the flagged frame
//   busy         out  high whenever the FSM is not IDLE
//   o_dbg_state  out  [2:0] current FSM state (IDLE=0 START=1 DATA=2
//                     PARITY=3 STOP=4) for observation
//
// Valid/ready: there is no back-pressure. po_flag is a pure valid strobe;
// the consumer must take po_data in the single cycle po_flag is high, or
// read the held value any time before the next po_flag.
// ---------------------------------------------------------------------------
module sd_uart_rx_gen2 #(
    parameter int CLK_FREQ  = 20_000_000,
    parameter int UART_BPS  = 921600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [2:0]           o_dbg_state
);

    localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int HALF     = BAUD_DIV / 2;

    localparam logic [CNT_W-1:0] C_SAMP0 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_SAMP1 = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] C_SAMP2 = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] C_END   = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       C_LAST  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic                   r_rx_s1;
    logic                   r_rx_s2;
    logic                   r_rx_d;
    logic [CNT_W-1:0]       r_baud_cnt;
    logic [3:0]             r_bit_idx;
    logic                   r_stop_idx;
    logic                   r_samp0;
    logic                   r_samp1;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bit;
    logic                   r_frame_acc;
    logic [DATA_BITS-1:0]   r_po_data;
    logic                   r_po_flag;
    logic                   r_parity_err;
    logic                   r_frame_err;

    logic                   w_start_edge;
    logic                   w_bit_end;
    logic                   w_decide;
    logic                   w_maj;
    logic                   w_last_data;
    logic                   w_last_stop;
    logic                   w_done;
    logic                   w_par_calc;
    logic                   w_par_err;

    // ---------------- next-state and decode ----------------
    always_comb begin
        w_start_edge = (r_state == S_IDLE) && !r_rx_s2 && r_rx_d;
        w_bit_end    = (r_baud_cnt == C_END);
        // The third sample is the live synchronised value, so the majority
        // is decided combinationally on the cycle of the last sample.
        w_decide     = (r_baud_cnt == C_SAMP2);
        w_maj        = (r_samp0 & r_samp1) | (r_samp0 & r_rx_s2) | (r_samp1 & r_rx_s2);
        w_last_data  = (r_bit_idx == C_LAST);
        w_last_stop  = (STOP_BITS == 1) || r_stop_idx;
        // Leaving at mid-bit of the last stop bit gives half a bit of margin
        // before the next start edge can arrive.
        w_done       = (r_state == S_STOP) && w_decide && w_last_stop;
        w_par_calc   = (^r_shift) ^ r_par_bit;
        w_par_err    = (PARITY == 1) ? !w_par_calc :
                       (PARITY == 2) ?  w_par_calc : 1'b0;

        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) w_next_state = S_START;
            end
            S_START: begin
                if (w_bit_end) w_next_state = S_DATA;
`ifdef SD_UART_RX_FALSE_START_EN
                if (w_decide && w_maj) w_next_state = S_IDLE;
`endif
            end
            S_DATA: begin
                if (w_bit_end && w_last_data)
                    w_next_state = (PARITY == 0) ? S_STOP : S_PARITY;
            end
            S_PARITY: begin
                if (w_bit_end) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_done) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next_state;
    end

    // ---------------- synchroniser and datapath ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_d       <= 1'b1;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_samp0      <= 1'b0;
            r_samp1      <= 1'b0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_frame_acc  <= 1'b0;
            r_po_data    <= '0;
            r_po_flag    <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;

            // Counter is held at 0 in IDLE so START begins at 0.
            if (r_state == S_IDLE || w_next_state == S_IDLE)
                r_baud_cnt <= '0;
            else if (w_bit_end)
                r_baud_cnt <= '0;
            else
                r_baud_cnt <= r_baud_cnt + CNT_W'(1);

            if (r_state != S_IDLE) begin
                if (r_baud_cnt == C_SAMP0) r_samp0 <= r_rx_s2;
                if (r_baud_cnt == C_SAMP1) r_samp1 <= r_rx_s2;
            end

            if (r_state == S_IDLE)
                r_bit_idx <= '0;
            else if (r_state == S_DATA && w_bit_end)
                r_bit_idx <= w_last_data ? 4'd0 : r_bit_idx + 4'd1;

            if (r_state == S_IDLE)
                r_stop_idx <= 1'b0;
            else if (r_state == S_STOP && w_bit_end)
                r_stop_idx <= 1'b1;

            // LSB arrives first, so shift in from the top.
            if (r_state == S_DATA && w_decide)
                r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};

            if (r_state == S_PARITY && w_decide)
                r_par_bit <= w_maj;

            if (r_state == S_IDLE)
                r_frame_acc <= 1'b0;
            else if (r_state == S_STOP && w_decide && !w_maj)
                r_frame_acc <= 1'b1;

            r_po_flag <= w_done;
            if (w_done) begin
                r_po_data    <= r_shift;
                r_parity_err <= w_par_err;
                r_frame_err  <= r_frame_acc | !w_maj;
            end
        end
    end

    assign po_data     = r_po_data;
    assign po_flag     = r_po_flag;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: doc/sd_uart_rx_gen2.md
SD_UART_RX_GEN2 -- requirements
Module: sd_uart_rx_gen2

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 20_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 921600, line baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have port sys_clk, input, 1 bit, the only clock; all logic on the rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-009 SHALL have port po_data, output, DATA_BITS bits, last received data word, LSB first on the line.
REQ-010 SHALL have port po_flag, output, 1 bit, one-cycle pulse marking po_data, parity_err and frame_err valid.
REQ-011 SHALL have port parity_err, output, 1 bit, parity mismatch on the frame flagged by po_flag; 0 when PARITY=0.
REQ-012 SHALL have port frame_err, output, 1 bit, a stop bit sampled low on the flagged frame.
REQ-013 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL define BAUD_DIV = CLK_FREQ/UART_BPS (integer division); BAUD_DIV >= 8 is required; the baud counter width is clog2(BAUD_DIV).
REQ-015 SHALL synchronise rx through two flops reset to 1, plus a third delay flop for edge detection.
REQ-016 SHALL detect a start edge when the synchronised rx is 0 and the delayed copy is 1, in IDLE only.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY and STOP; PARITY is skipped when PARITY=0.
REQ-018 SHALL enter START on the cycle after the edge, with baud_cnt=0; baud_cnt counts 0..BAUD_DIV-1 and clears on every bit boundary.
REQ-019 SHALL take three samples per bit at baud_cnt = BAUD_DIV/2-1, BAUD_DIV/2 and BAUD_DIV/2+1; the bit value is the 2-of-3 majority.
REQ-020 SHALL shift DATA bits in LSB first, advancing the bit index at baud_cnt = BAUD_DIV-1; leave DATA after DATA_BITS bits.
REQ-021 SHALL set parity_err, in PARITY state, when XOR(data bits, parity bit) is 0 for odd parity or 1 for even parity.
REQ-022 SHALL set frame_err when any stop bit's majority value is 0.
REQ-023 SHALL, on the cycle after the majority decision of the last stop bit:
- pulse po_flag for one cycle;
- update po_data, parity_err and frame_err in that same cycle;
- return to IDLE in that same cycle, giving half-bit resynchronisation margin.
REQ-024 SHALL hold po_data, parity_err and frame_err between flags.
REQ-025 SHALL still deliver po_data on a frame error.
REQ-026 SHALL NOT restart after a frame error until rx is seen high then low (no edge while the line is held low).
REQ-027 SHALL ignore rx edges while not in IDLE.

Reset
REQ-028 SHALL, on sys_rst_n low at any time including mid-frame, immediately:
- force po_data=0, po_flag=0, parity_err=0, frame_err=0, busy=0;
- set the FSM to IDLE and all counters to 0;
- set the synchroniser flops to 1.
REQ-029 SHALL NOT produce a po_flag for a frame interrupted by reset.

Configuration
REQ-030 SHALL provide macro SD_UART_RX_FALSE_START_EN: when defined, a START-bit majority of 1 returns the FSM to IDLE with no po_flag; when undefined, START always proceeds to DATA.

Verification (CLK_FREQ=20_000_000, UART_BPS=1_000_000, BAUD_DIV=20)
REQ-031 SHALL cover: 8N1 frame 0xA5 -> po_data=0xA5, single po_flag, parity_err=0, frame_err=0, busy low after flag.
REQ-032 SHALL cover: PARITY=2, data 0x3C with parity bit 1 -> po_data=0x3C, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-033 SHALL cover: 8N1 frame 0x55 with stop bit driven low -> po_flag, po_data=0x55, frame_err=1; line held low afterwards -> no further po_flag.
REQ-034 SHALL cover: a 5-cycle low glitch on an idle line -> with macro, no po_flag and busy back to 0 within 12 cycles; without macro, po_flag with po_data=0xFF.
REQ-035 SHALL cover: a 1-cycle inverted glitch at baud_cnt=BAUD_DIV/2 on data bit 3 of 0x00 -> po_data=0x00 (majority rejects it).
REQ-036 SHALL cover:
- back-to-back 8N2 frames 0x12, 0x34 -> two flags in order;
- sys_rst_n asserted mid-DATA -> all outputs 0 at once, no flag, next frame 0x77 received correctly.
